// File: rtl/mult_ctrl_fsm.sv
// Sequencer for the 4x4 two-bit-slice multiplier datapath: LOAD, four Horner-order
// partial products (HH, HL, LH, LL), then a one-cycle DONE pulse.
module mult_ctrl_fsm #(
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ld,
  output logic       acc_clr,
  output logic       s0,
  output logic       s2,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [1:0] step
);

  localparam int unsigned STEP_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    P_HH = 3'd2,
    P_HL = 3'd3,
    P_LH = 3'd4,
    P_LL = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                ld_nxt;
  logic                acc_clr_nxt;
  logic                s0_nxt;
  logic                s2_nxt;
  logic                s1_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic [STEP_W-1:0]   step_nxt;

  // State and output registers; outputs are decoded from the next state so they
  // line up with the state they belong to while coming straight off flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ld      <= 1'b0;
      acc_clr <= 1'b0;
      s0      <= 1'b0;
      s2      <= 1'b0;
      s1      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      step    <= '0;
    end else begin
      state   <= state_nxt;
      ld      <= ld_nxt;
      acc_clr <= acc_clr_nxt;
      s0      <= s0_nxt;
      s2      <= s2_nxt;
      s1      <= s1_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      step    <= step_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt   = IDLE;
    ld_nxt      = 1'b0;
    acc_clr_nxt = 1'b0;
    s0_nxt      = 1'b0;
    s2_nxt      = 1'b0;
    s1_nxt      = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    step_nxt    = '0;

    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = P_HH;
      P_HH:    state_nxt = P_HL;
      P_HL:    state_nxt = P_LH;
      P_LH:    state_nxt = P_LL;
      P_LL:    state_nxt = DONE;
      DONE:    state_nxt = (AUTO_RESTART && start) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase

    // s1 shifts the accumulator before the HL and LL terms (Horner order).
    case (state_nxt)
      LOAD: begin
        ld_nxt      = 1'b1;
        acc_clr_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end
      P_HH: begin
        s0_nxt   = 1'b1;
        s2_nxt   = 1'b1;
        busy_nxt = 1'b1;
        step_nxt = STEP_W'(0);
      end
      P_HL: begin
        s0_nxt   = 1'b1;
        s1_nxt   = 1'b1;
        busy_nxt = 1'b1;
        step_nxt = STEP_W'(1);
      end
      P_LH: begin
        s2_nxt   = 1'b1;
        busy_nxt = 1'b1;
        step_nxt = STEP_W'(2);
      end
      P_LL: begin
        s1_nxt   = 1'b1;
        busy_nxt = 1'b1;
        step_nxt = STEP_W'(3);
      end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Scoreboard bench: two controllers (AUTO_RESTART 0 and 1), each paired with a
// behavioural datapath; products are checked against plain a*b.
module tb_mult_ctrl_fsm;

  typedef struct {
    int         e;
    logic [7:0] prod;
  } job_t;

  logic       clk;
  logic       rst;
  logic [1:0] start_v;
  logic [1:0] ld_v, acc_v, s0_v, s1_v, s2_v, busy_v, done_v;
  logic [1:0] step_v [2];

  logic [3:0] a_in [2];
  logic [3:0] b_in [2];
  logic [3:0] ar   [2];
  logic [3:0] br   [2];
  logic [7:0] c_m  [2];

  job_t       jobs [2][$];
  int         next_ok [2];
  int         edge_cnt;
  int         checks;
  int         errors;

  logic       want_rst;
  logic [1:0] want_start;
  logic [3:0] want_a [2];
  logic [3:0] want_b [2];

  mult_ctrl_fsm #(.AUTO_RESTART(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .ld(ld_v[0]), .acc_clr(acc_v[0]),
    .s0(s0_v[0]), .s2(s2_v[0]), .s1(s1_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .step(step_v[0])
  );

  mult_ctrl_fsm #(.AUTO_RESTART(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .ld(ld_v[1]), .acc_clr(acc_v[1]),
    .s0(s0_v[1]), .s2(s2_v[1]), .s1(s1_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .step(step_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [7:0] pp(input logic [3:0] a, input logic [3:0] b,
                                    input logic sa, input logic sb);
    logic [7:0] x;
    logic [7:0] y;
    x = {6'b0, (sa ? a[3:2] : a[1:0])};
    y = {6'b0, (sb ? b[3:2] : b[1:0])};
    return x * y;
  endfunction

  // Behavioural 4x4 datapath driven by each controller's select lines.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ld_v[i] === 1'b1) begin
        ar[i] <= a_in[i];
        br[i] <= b_in[i];
      end
      if (acc_v[i] === 1'b1)
        c_m[i] <= 8'd0;
      else if (busy_v[i] === 1'b1)
        c_m[i] <= (s1_v[i] ? {c_m[i][5:0], 2'b00} : c_m[i]) + pp(ar[i], br[i], s0_v[i], s2_v[i]);
    end
  end

  // Expected output vector {ld,acc_clr,s0,s2,s1,busy,done,step} for a cycle
  // that lies ph cycles after the accepting edge.
  function automatic logic [8:0] exp_vec(input int ph);
    logic ld, ac, a, b, c, bz, dn;
    logic [1:0] st;
    {ld, ac, a, b, c, bz, dn} = 7'b0;
    st = 2'b00;
    if (ph == 0) begin
      ld = 1'b1; ac = 1'b1; bz = 1'b1;
    end else if (ph <= 4) begin
      bz = 1'b1;
      a  = (ph <= 2);
      b  = (ph % 2 == 1);
      c  = (ph % 2 == 0);
      st = 2'(ph - 1);
    end else begin
      dn = 1'b1;
    end
    return {ld, ac, a, b, c, bz, dn, st};
  endfunction

  task automatic check_inst(input int i);
    logic [8:0] exp;
    logic [8:0] act;
    int ph;
    job_t j;
    exp = '0;
    ph  = -1;
    if (jobs[i].size() > 0) begin
      ph = edge_cnt - jobs[i][0].e;
      if (ph >= 0 && ph <= 5) exp = exp_vec(ph);
    end
    act = {ld_v[i], acc_v[i], s0_v[i], s2_v[i], s1_v[i], busy_v[i], done_v[i], step_v[i]};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs inst%0d edge %0d: got %b expected %b", i, edge_cnt, act, exp);
    end
    if (done_v[i] === 1'b1) begin
      checks++;
      if (jobs[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_done inst%0d edge %0d: got done=1 expected no product pending", i, edge_cnt);
      end else begin
        j = jobs[i].pop_front();
        if (c_m[i] !== j.prod || edge_cnt != j.e + 5) begin
          errors++;
          $display("FAIL product inst%0d edge %0d: got c=%0d expected c=%0d at edge %0d",
                   i, edge_cnt, c_m[i], j.prod, j.e + 5);
        end
      end
    end else if (jobs[i].size() > 0 && ph > 5) begin
      checks++;
      errors++;
      $display("FAIL missing_done inst%0d edge %0d: got no done expected done at edge %0d",
               i, edge_cnt, jobs[i][0].e + 5);
      void'(jobs[i].pop_front());
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) check_inst(i);
  end

  // Apply the wanted inputs for the next edge and predict acceptance.
  task automatic tick();
    int k;
    job_t j;
    @(negedge clk);
    k = edge_cnt + 1;
    rst = want_rst;
    start_v = want_start;
    for (int i = 0; i < 2; i++) begin
      if (!want_rst) begin
        jobs[i].delete();
        next_ok[i] = k + 1;
      end else if (want_start[i] && k >= next_ok[i]) begin
        a_in[i] = want_a[i];
        b_in[i] = want_b[i];
        j.e = k;
        j.prod = 8'(want_a[i] * want_b[i]);
        jobs[i].push_back(j);
        next_ok[i] = k + ((i == 1) ? 6 : 7);
      end
    end
  endtask

  task automatic run_one(input int i, input logic [3:0] a, input logic [3:0] b);
    want_a[i] = a;
    want_b[i] = b;
    want_start[i] = 1'b1;
    tick();
    want_start[i] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_cnt = 0;
    next_ok[0] = 0;
    next_ok[1] = 0;
    for (int i = 0; i < 2; i++) begin
      a_in[i] = 4'd0; b_in[i] = 4'd0; ar[i] = 4'd0; br[i] = 4'd0; c_m[i] = 8'd0;
      want_a[i] = 4'd0; want_b[i] = 4'd0;
    end
    rst = 1'b0;
    start_v = 2'b11;
    want_rst = 1'b0;
    want_start = 2'b11;

    // Reset held with start high, then released with start low.
    repeat (2) tick();
    want_rst = 1'b1;
    want_start = 2'b00;
    repeat (4) tick();

    // Directed products on the non-restarting controller.
    run_one(0, 4'hF, 4'hF);
    run_one(0, 4'd6, 4'd9);
    run_one(0, 4'd0, 4'd13);
    run_one(0, 4'd1, 4'd1);

    // start reasserted while the HL product is in flight is ignored.
    want_a[0] = 4'd5; want_b[0] = 4'd11; want_start[0] = 1'b1;
    tick();
    want_start[0] = 1'b0;
    repeat (2) tick();
    want_a[0] = 4'd2; want_b[0] = 4'd2; want_start[0] = 1'b1;
    tick();
    want_start[0] = 1'b0;
    repeat (8) tick();

    // Reset during P_LH aborts the product; a fresh one must still be right.
    want_a[0] = 4'd9; want_b[0] = 4'd9; want_start[0] = 1'b1;
    tick();
    want_start[0] = 1'b0;
    repeat (3) tick();
    want_rst = 1'b0;
    tick();
    want_rst = 1'b1;
    repeat (2) tick();
    run_one(0, 4'd7, 4'd7);

    // start held high: one IDLE gap without restart, back-to-back with it.
    want_a[0] = 4'd3; want_b[0] = 4'd5;
    want_a[1] = 4'd3; want_b[1] = 4'd5;
    want_start = 2'b11;
    tick();
    want_a[1] = 4'd10; want_b[1] = 4'd12;
    want_a[0] = 4'd11; want_b[0] = 4'd13;
    repeat (19) tick();
    want_start = 2'b00;
    repeat (10) tick();

    // Randomised starts, operands and occasional resets on both controllers.
    for (int n = 0; n < 400; n++) begin
      want_rst = ($urandom % 97) != 0;
      for (int i = 0; i < 2; i++) begin
        want_start[i] = ($urandom % 3) == 0;
        want_a[i] = 4'($urandom);
        want_b[i] = 4'($urandom);
      end
      tick();
    end
    want_rst = 1'b1;
    want_start = 2'b00;
    repeat (10) tick();

    for (int i = 0; i < 2; i++) begin
      checks++;
      if (jobs[i].size() != 0) begin
        errors++;
        $display("FAIL drain inst%0d: got %0d products outstanding expected 0", i, jobs[i].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
